// File: rtl/alu_issue_stage_if.sv
// Issue-stage handshake bundle: decode-side request and writeback-side result.
// master = the surrounding pipeline, slave = alu_issue_stage.
interface alu_issue_stage_if #(
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [RD_W-1:0] in_rs1;
    logic [RD_W-1:0] in_rs2;
    logic [RD_W-1:0] in_rd;
    logic [31:0]     in_rs1_val;
    logic [31:0]     in_rs2_val;
    logic [31:0]     in_imm;
    logic            in_use_imm;
    logic            out_valid;
    logic            out_ready;
    logic [RD_W-1:0] out_rd;
    logic [31:0]     out_result;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd,
        output in_rs1_val, in_rs2_val, in_imm, in_use_imm,
        input  in_ready,
        input  out_valid, out_rd, out_result,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd,
        input  in_rs1_val, in_rs2_val, in_imm, in_use_imm,
        output in_ready,
        output out_valid, out_rd, out_result,
        input  out_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-stage ALU issue: E holds operands for the external ALU, R holds the result.
// Define ALU_ISSUE_BYPASS_EN to forward from E/R; otherwise RAW hazards stall.
module alu_issue_stage #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_stage_if.slave bus,
    input  logic            fwd_valid,
    input  logic [RD_W-1:0] fwd_rd,
    input  logic [31:0]     fwd_data,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [2:0]      alu_op,
    input  logic [31:0]     alu_out
);

    logic            e_valid_q, e_valid_d;
    logic            r_valid_q, r_valid_d;
    logic [RD_W-1:0] e_rd_q, e_rd_d;
    logic [31:0]     alu_a_q, alu_a_d;
    logic [31:0]     alu_b_q, alu_b_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic [RD_W-1:0] out_rd_q, out_rd_d;
    logic [31:0]     out_result_q, out_result_d;

    logic        e_adv;
    logic        stall;
    logic        in_ready;
    logic        take;
    logic        use_rs2;
    logic [31:0] a_val;
    logic [31:0] b_val;

    // Register 0 is hard-wired, so it never aliases a producer.
    function automatic logic hit(logic [RD_W-1:0] rs, logic [RD_W-1:0] rd);
        return (rs != '0) && (rs == rd);
    endfunction

    // Later assignments override earlier ones: youngest producer wins.
    always_comb begin
        a_val = bus.in_rs1_val;
        b_val = bus.in_rs2_val;
        if (fwd_valid && hit(bus.in_rs1, fwd_rd)) a_val = fwd_data;
        if (fwd_valid && hit(bus.in_rs2, fwd_rd)) b_val = fwd_data;
`ifdef ALU_ISSUE_BYPASS_EN
        if (r_valid_q && hit(bus.in_rs1, out_rd_q)) a_val = out_result_q;
        if (r_valid_q && hit(bus.in_rs2, out_rd_q)) b_val = out_result_q;
        if (e_valid_q && hit(bus.in_rs1, e_rd_q)) a_val = alu_out;
        if (e_valid_q && hit(bus.in_rs2, e_rd_q)) b_val = alu_out;
`endif
    end

    always_comb begin
        use_rs2 = !bus.in_use_imm;
        e_adv   = e_valid_q && (!r_valid_q || bus.out_ready);
`ifdef ALU_ISSUE_BYPASS_EN
        stall = 1'b0;
`else
        stall = (e_valid_q && (hit(bus.in_rs1, e_rd_q) ||
                               (use_rs2 && hit(bus.in_rs2, e_rd_q)))) ||
                (r_valid_q && (hit(bus.in_rs1, out_rd_q) ||
                               (use_rs2 && hit(bus.in_rs2, out_rd_q))));
`endif
        in_ready = (!e_valid_q || e_adv) && !stall;
        take     = bus.in_valid && in_ready;
    end

    always_comb begin
        e_valid_d    = e_valid_q;
        r_valid_d    = r_valid_q;
        e_rd_d       = e_rd_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        out_rd_d     = out_rd_q;
        out_result_d = out_result_q;
        if (e_adv) begin
            r_valid_d    = 1'b1;
            out_rd_d     = e_rd_q;
            out_result_d = alu_out;
        end else if (bus.out_ready) begin
            r_valid_d = 1'b0;
        end
        if (take) begin
            e_valid_d = 1'b1;
            e_rd_d    = bus.in_rd;
            alu_a_d   = a_val;
            alu_b_d   = use_rs2 ? b_val : bus.in_imm;
            alu_op_d  = bus.in_op;
        end else if (e_adv) begin
            e_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q    <= 1'b0;
            r_valid_q    <= 1'b0;
            e_rd_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            out_rd_q     <= '0;
            out_result_q <= '0;
        end else begin
            e_valid_q    <= e_valid_d;
            r_valid_q    <= r_valid_d;
            e_rd_q       <= e_rd_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            out_rd_q     <= out_rd_d;
            out_result_q <= out_result_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = r_valid_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_result = out_result_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural external ALU.
// Hazard expectations follow ALU_ISSUE_BYPASS_EN.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;

    alu_issue_stage_if #(.RD_W(5)) bus ();

    alu_issue_stage #(.RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
    );

`ifdef ALU_ISSUE_BYPASS_EN
    localparam int HZ_STALL = 0;
    localparam logic [31:0] HZ_RES = 32'd5;
    localparam logic [31:0] PRI_A = 32'd7;
`else
    localparam int HZ_STALL = 2;
    localparam logic [31:0] HZ_RES = 32'd100;
    localparam logic [31:0] PRI_A = 32'd100;
`endif

    always_comb begin
        case (alu_op)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = alu_a << alu_b[4:0];
            3'd6: alu_out = alu_a >> alu_b[4:0];
            default: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic        use_imm;
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
    } ret_t;

    ret_t rq[$];
    int   base;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk)
        if (rst_n && bus.out_valid && bus.out_ready)
            rq.push_back('{bus.out_rd, bus.out_result});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        bus.in_op      = v.op;
        bus.in_rs1     = v.rs1;
        bus.in_rs2     = v.rs2;
        bus.in_rd      = v.rd;
        bus.in_rs1_val = v.v1;
        bus.in_rs2_val = v.v2;
        bus.in_imm     = v.imm;
        bus.in_use_imm = v.use_imm;
        fwd_valid      = v.fv;
        fwd_rd         = v.frd;
        fwd_data       = v.fdata;
        bus.in_valid   = 1'b1;
    endtask

    task automatic wait_accept(output int stalls);
        bit got;
        got = 0;
        stalls = 0;
        while (!got && stalls < 20) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no in_ready after %0d cycles", stalls);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        fwd_valid    = 1'b0;
    endtask

    task automatic drain(input int n);
        int k;
        k = 0;
        while (rq.size() < base + n && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_count", rq.size() - base, n);
    endtask

    function automatic ret_t rget(input int i);
        ret_t r;
        r = '{5'd0, 32'd0};
        if (base + i < rq.size()) r = rq[base + i];
        return r;
    endfunction

    vec_t tbl[13];
    vec_t v;
    int   st;

    initial begin
        tbl[0]  = '{3'd0, 5'd1, 5'd2, 5'd5, 32'd100, 32'd23, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd123};
        tbl[1]  = '{3'd1, 5'd1, 5'd2, 5'd6, 32'd50, 32'd9, 32'd8, 1'b1, 1'b0, 5'd0, 32'd0, 32'd42};
        tbl[2]  = '{3'd2, 5'd3, 5'd4, 5'd7, 32'hffff0000, 32'h0ff00ff0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0ff00000};
        tbl[3]  = '{3'd3, 5'd3, 5'd4, 5'd8, 32'h000000f0, 32'h0000000f, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h000000ff};
        tbl[4]  = '{3'd4, 5'd3, 5'd4, 5'd9, 32'haaaaaaaa, 32'hffffffff, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h55555555};
        tbl[5]  = '{3'd5, 5'd3, 5'd4, 5'd10, 32'd1, 32'd31, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h80000000};
        tbl[6]  = '{3'd6, 5'd3, 5'd4, 5'd11, 32'h80000000, 32'd4, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h08000000};
        tbl[7]  = '{3'd7, 5'd3, 5'd4, 5'd12, 32'hffffffff, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd1};
        tbl[8]  = '{3'd0, 5'd6, 5'd2, 5'd13, 32'd1, 32'd0, 32'd5, 1'b1, 1'b1, 5'd6, 32'd1000, 32'd1005};
        tbl[9]  = '{3'd1, 5'd1, 5'd7, 5'd14, 32'd10, 32'd3, 32'd0, 1'b0, 1'b1, 5'd7, 32'd20, 32'hfffffff6};
        tbl[10] = '{3'd0, 5'd1, 5'd7, 5'd15, 32'd10, 32'd3, 32'd3, 1'b1, 1'b1, 5'd7, 32'd20, 32'd13};
        tbl[11] = '{3'd0, 5'd0, 5'd2, 5'd16, 32'd7, 32'd0, 32'd1, 1'b1, 1'b1, 5'd0, 32'd555, 32'd8};
        tbl[12] = '{3'd0, 5'd1, 5'd2, 5'd17, 32'hffffffff, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};

        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        set_in('{3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0});
        bus.in_valid = 1'b0;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_rd", bus.out_rd, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            base = rq.size();
            set_in(tbl[i]);
            wait_accept(st);
            idle();
            drain(1);
            chk($sformatf("vec%0d_rd", i), rget(0).rd, tbl[i].rd);
            chk($sformatf("vec%0d_res", i), rget(0).res, tbl[i].exp);
        end

        // back-to-back, 2-cycle latency
        base = rq.size();
        set_in('{3'd0, 5'd1, 5'd0, 5'd1, 32'd5, 32'd0, 32'd3, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        set_in('{3'd1, 5'd5, 5'd6, 5'd2, 32'd10, 32'd4, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0});
        @(negedge clk);
        chk("b2b_in_ready", bus.in_ready, 1);
        chk("b2b_lat_valid0", bus.out_valid, 0);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("b2b_valid1", bus.out_valid, 1);
        chk("b2b_res1", bus.out_result, 8);
        chk("b2b_rd1", bus.out_rd, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_valid2", bus.out_valid, 1);
        chk("b2b_res2", bus.out_result, 6);
        chk("b2b_rd2", bus.out_rd, 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_drained", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // back-pressure
        base = rq.size();
        bus.out_ready = 1'b0;
        set_in('{3'd0, 5'd0, 5'd0, 5'd20, 32'd11, 32'd0, 32'd1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        set_in('{3'd0, 5'd0, 5'd0, 5'd21, 32'd22, 32'd0, 32'd2, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        set_in('{3'd0, 5'd0, 5'd0, 5'd22, 32'd33, 32'd0, 32'd3, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_res", bus.out_result, 12);
            chk("bp_hold_rd", bus.out_rd, 20);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        wait_accept(st);
        chk("bp_release_stall", st, 0);
        idle();
        drain(3);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_dup", rq.size() - base, 3);
        chk("bp_r0", rget(0).res, 12);
        chk("bp_r1", rget(1).res, 24);
        chk("bp_r2", rget(2).res, 36);
        chk("bp_rd2", rget(2).rd, 22);

        // RAW hazard on rd=3
        base = rq.size();
        set_in('{3'd0, 5'd1, 5'd0, 5'd3, 32'd2, 32'd0, 32'd2, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        set_in('{3'd0, 5'd3, 5'd0, 5'd4, 32'd99, 32'd0, 32'd1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        chk("hz_stall", st, HZ_STALL);
        idle();
        drain(2);
        chk("hz_first", rget(0).res, 4);
        chk("hz_second", rget(1).res, HZ_RES);

        // E-stage source beats fwd port
        base = rq.size();
        set_in('{3'd0, 5'd0, 5'd0, 5'd4, 32'd3, 32'd0, 32'd4, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        set_in('{3'd0, 5'd4, 5'd0, 5'd9, 32'd1, 32'd0, 32'd0, 1'b1, 1'b1, 5'd4, 32'd100, 32'd0});
        wait_accept(st);
        chk("pri_alu_a", alu_a, PRI_A);
        idle();
        drain(2);
        chk("pri_first", rget(0).res, 7);
        chk("pri_second", rget(1).res, PRI_A);

        // rs1=0 against E rd=0
        base = rq.size();
        set_in('{3'd0, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        set_in('{3'd0, 5'd0, 5'd0, 5'd18, 32'd33, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        chk("zero_stall", st, 0);
        chk("zero_alu_a", alu_a, 33);
        idle();
        drain(2);
        chk("zero_first", rget(0).res, 10);
        chk("zero_second", rget(1).res, 33);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold_a", alu_a, 33);
        chk("idle_hold_b", alu_b, 0);

        // reset with two in flight
        bus.out_ready = 1'b0;
        set_in('{3'd0, 5'd0, 5'd0, 5'd25, 32'd40, 32'd0, 32'd2, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        set_in('{3'd1, 5'd0, 5'd0, 5'd26, 32'd50, 32'd0, 32'd5, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0});
        wait_accept(st);
        idle();
        @(negedge clk);
        chk("pre_rst_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_result", bus.out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        base = rq.size();
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_retired", rq.size() - base, 0);
        chk("post_rst_valid", bus.out_valid, 0);
        chk("post_rst_in_ready", bus.in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
